// File: rtl/mw_chk_pkg.sv
// rtl/mw_chk_pkg.sv - shared types for the memory-write checker
// Contents:
//   state_e      checker FSM states
//   fail_code_e  failure reason reported on fail_code_o
//   exp_entry_t  default-width (32/32) expected store entry
package mw_chk_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_ADDR    = 2'd1,
      FC_DATA    = 2'd2,
      FC_TIMEOUT = 2'd3
   } fail_code_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_entry_t;

endpackage

// File: rtl/mw_exp_table.sv
// rtl/mw_exp_table.sv - expected-store table with per-entry comparators
// Ports:
//   clk          clock
//   we           write enable (already qualified by the caller)
//   idx          entry index to write
//   addr, data   entry contents to write
//   cmp_addr     observed store address
//   cmp_data     observed store data
//   addr_match   per-entry address equality
//   full_match   per-entry address and data equality
// Contents are intentionally not reset so a program survives reset.
module mw_exp_table #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int N_EXP  = 8,
   parameter int IW     = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IW-1:0]     idx,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] cmp_addr,
   input  logic [DATA_W-1:0] cmp_data,
   output logic [N_EXP-1:0]  addr_match,
   output logic [N_EXP-1:0]  full_match
);

   logic [ADDR_W-1:0] addr_mem [N_EXP];
   logic [DATA_W-1:0] data_mem [N_EXP];

   // Indices beyond the table (non-power-of-two depth) are dropped.
   always_ff @(posedge clk) begin
      if (we && (int'(idx) < N_EXP)) begin
         addr_mem[idx] <= addr;
         data_mem[idx] <= data;
      end
   end

   for (genvar i = 0; i < N_EXP; i++) begin : g_cmp
      assign addr_match[i] = (addr_mem[i] == cmp_addr);
      assign full_match[i] = addr_match[i] && (data_mem[i] == cmp_data);
   end

endmodule

// File: rtl/memwrite_checker.sv
// rtl/memwrite_checker.sv - store-stream checker for the MIPS data-memory write port
// Ports:
//   clk_i, reset_i                     clock, sync active-high reset
//   memwrite_i, dataadr_i, writedata_i observed store strobe/address/data
//   exp_we_i, exp_idx_i, exp_addr_i, exp_data_i  expected-table write (IDLE only)
//   n_exp_i, ordered_i                 entries to match and ordering mode, taken at start
//   scratch_lo_i, scratch_hi_i         inclusive ignore range (lo>hi disables)
//   start_i, clear_i                   IDLE->RUN, any->IDLE
//   done_o, pass_o                     terminal state reached, PASS reached
//   fail_code_o, fail_addr_o, fail_data_o  failure reason and offending store
//   match_cnt_o, cycle_cnt_o           entries matched, cycles spent in RUN
module memwrite_checker
   import mw_chk_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int N_EXP   = 8,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 4096,
   localparam int IW     = (N_EXP > 1) ? $clog2(N_EXP) : 1,
   localparam int CW     = $clog2(N_EXP + 1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              memwrite_i,
   input  logic [ADDR_W-1:0] dataadr_i,
   input  logic [DATA_W-1:0] writedata_i,
   input  logic              exp_we_i,
   input  logic [IW-1:0]     exp_idx_i,
   input  logic [ADDR_W-1:0] exp_addr_i,
   input  logic [DATA_W-1:0] exp_data_i,
   input  logic [CW-1:0]     n_exp_i,
   input  logic              ordered_i,
   input  logic [ADDR_W-1:0] scratch_lo_i,
   input  logic [ADDR_W-1:0] scratch_hi_i,
   input  logic              start_i,
   input  logic              clear_i,
   output logic              done_o,
   output logic              pass_o,
   output logic [1:0]        fail_code_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_data_o,
   output logic [CW-1:0]     match_cnt_o,
   output logic [CNT_W-1:0]  cycle_cnt_o
);

   state_e            state_q, state_d;
   logic [CW-1:0]     n_req_q;
   logic              ordered_q;
   logic [N_EXP-1:0]  hit_q;
   logic [CW-1:0]     match_cnt_q;
   logic [CNT_W-1:0]  cycle_cnt_q;
   fail_code_e        fail_code_q, fail_code_d;
   logic [ADDR_W-1:0] fail_addr_q;
   logic [DATA_W-1:0] fail_data_q;

   logic [N_EXP-1:0]  addr_match, full_match, pending, addr_hit, full_hit, hit_set;
   logic              in_scratch, take_match, take_fail;

   mw_exp_table #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .N_EXP  (N_EXP),
      .IW     (IW)
   ) u_table (
      .clk        (clk_i),
      .we         (exp_we_i && (state_q == ST_IDLE)),
      .idx        (exp_idx_i),
      .addr       (exp_addr_i),
      .data       (exp_data_i),
      .cmp_addr   (dataadr_i),
      .cmp_data   (writedata_i),
      .addr_match (addr_match),
      .full_match (full_match)
   );

   // Pending entries: in ordered mode only the entry at the match pointer,
   // otherwise every active entry not yet hit. Both modes share the match path.
   always_comb begin
      pending = '0;
      for (int i = 0; i < N_EXP; i++) begin
         if (CW'(i) < n_req_q)
            pending[i] = ordered_q ? (CW'(i) == match_cnt_q) : !hit_q[i];
      end
   end

   assign full_hit   = full_match & pending;
   assign addr_hit   = addr_match & pending;
   assign in_scratch = (scratch_lo_i <= scratch_hi_i) &&
                       (dataadr_i >= scratch_lo_i) && (dataadr_i <= scratch_hi_i);

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      take_match  = 1'b0;
      take_fail   = 1'b0;
      hit_set     = '0;
      fail_code_d = FC_NONE;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (n_req_q == '0) begin
               state_d = ST_PASS;
            end else if (memwrite_i && (|full_hit)) begin
               take_match = 1'b1;
               // lowest-index matching entry only
               hit_set    = full_hit & (~full_hit + N_EXP'(1));
               if (match_cnt_q + CW'(1) == n_req_q) state_d = ST_PASS;
            end else if (memwrite_i && !in_scratch) begin
               take_fail   = 1'b1;
               fail_code_d = (|addr_hit) ? FC_DATA : FC_ADDR;
               state_d     = ST_FAIL;
            end
            // a store resolving on the last allowed cycle beats the timeout
            if ((state_d == ST_RUN) && (cycle_cnt_q == CNT_W'(TIMEOUT - 1)))
               state_d = ST_TIMEOUT;
         end
         default: ;
      endcase
      if (clear_i) state_d = ST_IDLE;
   end

   // The cycle counter advances only while RUN continues, so the terminal
   // state reports the count of the cycle on which it resolved.
   always_ff @(posedge clk_i) begin
      if (reset_i || clear_i) begin
         n_req_q     <= '0;
         ordered_q   <= 1'b0;
         hit_q       <= '0;
         match_cnt_q <= '0;
         cycle_cnt_q <= '0;
         fail_code_q <= FC_NONE;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else if ((state_q == ST_IDLE) && start_i) begin
         n_req_q     <= (n_exp_i > CW'(N_EXP)) ? CW'(N_EXP) : n_exp_i;
         ordered_q   <= ordered_i;
         hit_q       <= '0;
         match_cnt_q <= '0;
         cycle_cnt_q <= '0;
         fail_code_q <= FC_NONE;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else if (state_q == ST_RUN) begin
         if (take_match) begin
            hit_q       <= hit_q | hit_set;
            match_cnt_q <= match_cnt_q + CW'(1);
         end
         if (take_fail) begin
            fail_code_q <= fail_code_d;
            fail_addr_q <= dataadr_i;
            fail_data_q <= writedata_i;
         end else if (state_d == ST_TIMEOUT) begin
            fail_code_q <= FC_TIMEOUT;
         end
         if (state_d == ST_RUN) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end
   end

   assign done_o      = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
   assign pass_o      = (state_q == ST_PASS);
   assign fail_code_o = fail_code_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_data_o = fail_data_q;
   assign match_cnt_o = match_cnt_q;
   assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_memwrite_checker.sv
// tb/tb_memwrite_checker.sv - scoreboard bench for memwrite_checker
module tb_memwrite_checker;
   import mw_chk_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NE = 2;
   localparam int TO = 20;
   localparam int IW = 1;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          memwrite = 1'b0;
   logic [AW-1:0] dataadr = '0;
   logic [DW-1:0] writedata = '0;
   logic          exp_we = 1'b0;
   logic [IW-1:0] exp_idx = '0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_data = '0;
   logic [CW-1:0] n_exp = '0;
   logic          ordered = 1'b0;
   logic [AW-1:0] scratch_lo = 32'd80;
   logic [AW-1:0] scratch_hi = 32'd80;
   logic          start = 1'b0;
   logic          clear = 1'b0;
   logic          done, pass;
   logic [1:0]    fail_code;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;
   logic [CW-1:0] match_cnt;
   logic [31:0]   cycle_cnt;

   int tests = 0;
   int errors = 0;

   typedef struct {
      bit          pass;
      logic [1:0]  code;
      bit          chk_code;
      logic [31:0] faddr;
      logic [31:0] fdata;
      logic [1:0]  mcnt;
      logic [31:0] ccnt;
   } result_t;

   result_t sb[$];

   memwrite_checker #(
      .ADDR_W (AW), .DATA_W (DW), .N_EXP (NE), .CNT_W (32), .TIMEOUT (TO)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .memwrite_i   (memwrite),
      .dataadr_i    (dataadr),
      .writedata_i  (writedata),
      .exp_we_i     (exp_we),
      .exp_idx_i    (exp_idx),
      .exp_addr_i   (exp_addr),
      .exp_data_i   (exp_data),
      .n_exp_i      (n_exp),
      .ordered_i    (ordered),
      .scratch_lo_i (scratch_lo),
      .scratch_hi_i (scratch_hi),
      .start_i      (start),
      .clear_i      (clear),
      .done_o       (done),
      .pass_o       (pass),
      .fail_code_o  (fail_code),
      .fail_addr_o  (fail_addr),
      .fail_data_o  (fail_data),
      .match_cnt_o  (match_cnt),
      .cycle_cnt_o  (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int idx, input exp_entry_t e);
      exp_we = 1'b1; exp_idx = IW'(idx); exp_addr = e.addr; exp_data = e.data;
      tick();
      exp_we = 1'b0;
   endtask

   task automatic begin_run(input int n, input bit ord);
      n_exp = CW'(n); ordered = ord; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; dataadr = a; writedata = d;
      tick();
      memwrite = 1'b0;
   endtask

   task automatic expect_result(input bit p, input logic [1:0] c, input bit cc,
                                input logic [31:0] fa, input logic [31:0] fd,
                                input logic [1:0] mc, input logic [31:0] cyc);
      result_t r;
      r.pass = p; r.code = c; r.chk_code = cc; r.faddr = fa; r.fdata = fd;
      r.mcnt = mc; r.ccnt = cyc;
      sb.push_back(r);
   endtask

   task automatic finish_case(input string name);
      int k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         tests++;
         errors++;
         $display("FAIL %s_wait_done: got done=0 expected done=1 within 40 cycles", name);
      end
      @(posedge clk); #1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Monitor: compares each newly reached terminal state with the next expectation.
   initial begin
      bit      prev = 1'b0;
      result_t e;
      forever begin
         @(negedge clk);
         if (done && !prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("pass", 32'(pass), 32'(e.pass));
               if (e.chk_code) chk("fail_code", 32'(fail_code), 32'(e.code));
               chk("fail_addr", fail_addr, e.faddr);
               chk("fail_data", fail_data, e.fdata);
               chk("match_cnt", 32'(match_cnt), 32'(e.mcnt));
               chk("cycle_cnt", cycle_cnt, e.ccnt);
            end
         end
         prev = done;
      end
   end

   initial begin
      tick(); tick();
      reset = 1'b0;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_code", 32'(fail_code), 32'd0);
      chk("rst_cycle", cycle_cnt, 32'd0);

      prog(0, '{addr: 32'd84, data: 32'd7});
      prog(1, '{addr: 32'd88, data: 32'd9});

      // ordered, one entry, scratch store ignored
      expect_result(1, 2'd0, 1, 0, 0, 2'd1, 32'd1);
      begin_run(1, 1); store(80, 5); store(84, 7);
      finish_case("ord_scratch");

      // ordered, out-of-order store fails at 88
      expect_result(0, 2'd0, 0, 32'd88, 32'd9, 2'd0, 32'd0);
      begin_run(2, 1); store(88, 9);
      finish_case("ord_out_of_order");

      // ordered, right address wrong data
      expect_result(0, 2'd2, 1, 32'd84, 32'd5, 2'd0, 32'd0);
      begin_run(2, 1); store(84, 5);
      finish_case("ord_bad_data");

      // unordered, reverse order passes
      expect_result(1, 2'd0, 1, 0, 0, 2'd2, 32'd1);
      begin_run(2, 0); store(88, 9); store(84, 7);
      finish_case("unord_pass");

      // unordered, unknown address
      expect_result(0, 2'd1, 1, 32'd92, 32'd1, 2'd0, 32'd0);
      begin_run(2, 0); store(92, 1);
      finish_case("unord_bad_addr");

      // unordered, matched entry re-stored is no longer pending
      expect_result(0, 2'd1, 1, 32'd84, 32'd7, 2'd1, 32'd1);
      begin_run(2, 0); store(84, 7); store(84, 7);
      finish_case("unord_restore");

      // unordered, pending address with wrong data
      expect_result(0, 2'd2, 1, 32'd88, 32'd3, 2'd0, 32'd0);
      begin_run(2, 0); store(88, 3);
      finish_case("unord_bad_data");

      // timeout with no stores
      expect_result(0, 2'd3, 1, 0, 0, 2'd0, 32'd19);
      begin_run(2, 1);
      finish_case("timeout");

      // matching store on the timeout cycle wins
      expect_result(1, 2'd0, 1, 0, 0, 2'd1, 32'd19);
      begin_run(1, 1);
      repeat (19) tick();
      store(84, 7);
      finish_case("timeout_edge");

      // reset mid-run after one match
      begin_run(2, 0); store(84, 7);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_pass", 32'(pass), 32'd0);
      chk("mid_rst_code", 32'(fail_code), 32'd0);
      chk("mid_rst_faddr", fail_addr, 32'd0);
      chk("mid_rst_fdata", fail_data, 32'd0);
      chk("mid_rst_match", 32'(match_cnt), 32'd0);
      chk("mid_rst_cycle", cycle_cnt, 32'd0);
      expect_result(1, 2'd0, 1, 0, 0, 2'd2, 32'd1);
      begin_run(2, 0); store(88, 9); store(84, 7);
      finish_case("restart");

      // n_exp = 0: PASS two cycles after start
      expect_result(1, 2'd0, 1, 0, 0, 2'd0, 32'd0);
      begin_run(0, 1);
      chk("n0_pass_early", 32'(pass), 32'd0);
      tick();
      chk("n0_pass", 32'(pass), 32'd1);
      finish_case("n_exp_zero");

      // n_exp clamps to N_EXP; table write during RUN is ignored
      expect_result(1, 2'd0, 1, 0, 0, 2'd2, 32'd2);
      begin_run(3, 1);
      prog(0, '{addr: 32'd100, data: 32'd1});
      store(84, 7); store(88, 9);
      finish_case("clamp_we_run");

      // clear and start together: stays IDLE
      clear = 1'b1; start = 1'b1; n_exp = 2'd2;
      tick();
      clear = 1'b0; start = 1'b0;
      tick(); tick(); tick();
      chk("clr_start_done", 32'(done), 32'd0);
      chk("clr_start_cycle", cycle_cnt, 32'd0);

      tick(); tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
